// File: rtl/pll_rst_seq.sv
// pll_rst_seq: reset sequencer around the PLL. Pulses the PLL reset, qualifies
// lock through a 2-flop synchronizer, then releases NUM_RST active-low domain
// resets in a staggered order. Lock loss or lock timeout re-runs the sequence.
// Optional macro: PLL_RST_SEQ_GLITCH_FILTER_EN -- in RUN, lock loss is acted on
// only after four consecutive low cycles of the synchronized lock.
module pll_rst_seq #(
    parameter int unsigned RST_PULSE    = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned STABLE_CYC   = 1024,
    parameter int unsigned NUM_RST      = 3,
    parameter int unsigned STAGGER      = 8,
    parameter int unsigned CNT_W        = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] rst_n_o,
    output logic               ready,
    output logic [2:0]         state_o,
    output logic [7:0]         retry_cnt
);

    localparam int unsigned RETRY_W = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [NUM_RST-1:0]   rst_n_q, rst_n_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 ready_q, ready_d;
    logic [1:0]           sync_q;
    logic                 lock_s;
    logic                 rel_tick;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
    logic [1:0]           low_q, low_d;
`endif

    assign lock_s    = sync_q[1];
    assign pll_rst   = pll_rst_q;
    assign rst_n_o   = rst_n_q;
    assign ready     = ready_q;
    assign state_o   = state_q;
    assign retry_cnt = retry_q;

    // Two-flop synchronizer for the asynchronous PLL lock pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            timer_q   <= '0;
            retry_q   <= '0;
            rst_n_q   <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            rst_n_q   <= rst_n_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
        end
    end

`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
    // Consecutive-low counter for the RUN-state glitch filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_q <= 2'd0;
        end else begin
            low_q <= low_d;
        end
    end
`endif

    // Next-state, timer and output decode.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        rst_n_d   = rst_n_q;
        rel_tick  = 1'b0;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
        low_d     = 2'd0;
`endif

        case (state_q)
            PLL_RST: begin
                if (timer_q == CNT_W'(RST_PULSE - 1)) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (timer_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = PLL_RST;
                    retry_d = (retry_q == '1) ? retry_q : retry_q + 8'd1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == CNT_W'(STABLE_CYC - 1)) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    retry_d = (retry_q == '1) ? retry_q : retry_q + 8'd1;
                end else if (!rst_n_q[0] || (timer_q == CNT_W'(STAGGER - 1))) begin
                    // Shift in one more released bit; bit 0 goes first.
                    rel_tick = 1'b1;
                    rst_n_d  = NUM_RST'({rst_n_q, 1'b1});
                    if (rst_n_d[NUM_RST-1]) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
                if (!lock_s) begin
                    if (low_q == 2'd3) begin
                        state_d = PLL_RST;
                        retry_d = (retry_q == '1) ? retry_q : retry_q + 8'd1;
                    end else begin
                        low_d = low_q + 2'd1;
                    end
                end
`else
                if (!lock_s) begin
                    state_d = PLL_RST;
                    retry_d = (retry_q == '1) ? retry_q : retry_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        // Timer restarts on every state entry and on every release tick.
        if ((state_d != state_q) || rel_tick) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        // Domain resets are only ever released in RELEASE/RUN; all reassert together.
        if ((state_d != RELEASE) && (state_d != RUN)) begin
            rst_n_d = '0;
        end

        pll_rst_d = (state_d == PLL_RST);
        ready_d   = (state_d == RUN);
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed + randomized bench for pll_rst_seq with a
// cycle-level behavioural reference model.
module tb_pll_rst_seq;

    localparam int unsigned RST_PULSE    = 4;
    localparam int unsigned LOCK_TIMEOUT = 20;
    localparam int unsigned STABLE_CYC   = 8;
    localparam int unsigned NUM_RST      = 3;
    localparam int unsigned STAGGER      = 2;
    localparam int unsigned CNT_W        = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               pll_lock;
    logic               pll_rst;
    logic [NUM_RST-1:0] rst_n_o;
    logic               ready;
    logic [2:0]         state_o;
    logic [7:0]         retry_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: phase 0..4 = pulse, wait lock, stable, release, run.
    int m_phase;
    int m_t;
    int m_retry;
    int m_low;
    bit pin_q[$];

    always #5 clk = ~clk;

    pll_rst_seq #(
        .RST_PULSE   (RST_PULSE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYC  (STABLE_CYC),
        .NUM_RST     (NUM_RST),
        .STAGGER     (STAGGER),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .pll_rst  (pll_rst),
        .rst_n_o  (rst_n_o),
        .ready    (ready),
        .state_o  (state_o),
        .retry_cnt(retry_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_t     = 0;
        m_retry = 0;
        m_low   = 0;
        pin_q.delete();
        pin_q.push_back(1'b0);
        pin_q.push_back(1'b0);
        cyc = 0;
    endtask

    function automatic logic [NUM_RST-1:0] exp_rst();
        logic [NUM_RST-1:0] e;
        int k;
        e = '0;
        k = 0;
        if (m_phase == 4) begin
            k = NUM_RST;
        end else if (m_phase == 3 && m_t > 0) begin
            k = (m_t - 1) / STAGGER + 1;
            if (k > NUM_RST) k = NUM_RST;
        end
        for (int i = 0; i < NUM_RST; i++) e[i] = (i < k);
        return e;
    endfunction

    task automatic compare_all();
        chk("pll_rst",   32'(pll_rst),   32'(m_phase == 0));
        chk("rst_n_o",   32'(rst_n_o),   32'(exp_rst()));
        chk("ready",     32'(ready),     32'(m_phase == 4));
        chk("state_o",   32'(state_o),   32'(m_phase));
        chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    endtask

    // Called mid-cycle (negedge): check this cycle, drive the pin, advance the model.
    task automatic step(input bit v);
        bit ls;
        int nxt;
        compare_all();
        pll_lock = v;
        ls = pin_q.pop_front();
        pin_q.push_back(v);
        nxt = m_phase;
        case (m_phase)
            0: if (m_t == RST_PULSE - 1) nxt = 1;
            1: begin
                if (ls) nxt = 2;
                else if (m_t == LOCK_TIMEOUT - 1) begin
                    nxt = 0;
                    if (m_retry < 255) m_retry++;
                end
            end
            2: begin
                if (!ls) nxt = 1;
                else if (m_t == STABLE_CYC - 1) nxt = 3;
            end
            3: begin
                if (!ls) begin
                    nxt = 0;
                    if (m_retry < 255) m_retry++;
                end else if (m_t == (NUM_RST - 1) * STAGGER) nxt = 4;
            end
            default: begin
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
                if (!ls) begin
                    m_low++;
                    if (m_low == 4) begin
                        nxt = 0;
                        if (m_retry < 255) m_retry++;
                    end
                end else m_low = 0;
`else
                if (!ls) begin
                    nxt = 0;
                    if (m_retry < 255) m_retry++;
                end
`endif
            end
        endcase
        if (nxt != 4) m_low = 0;
        m_t     = (nxt != m_phase) ? 0 : m_t + 1;
        m_phase = nxt;
        @(negedge clk);
        cyc++;
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Leaves the bench at a negedge with rst_n just released (cycle 0).
    task automatic do_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b0;

        // Nominal lock 10 cycles after release, then 1-cycle lock loss in RUN.
        do_reset();
        hold(1'b0, 10);
        hold(1'b1, 30);
        hold(1'b0, 1);
        hold(1'b1, 40);
        // Longer drops in RUN (filter boundary when the macro is set).
        for (int len = 2; len <= 5; len++) begin
            hold(1'b0, len);
            hold(1'b1, 40);
        end

        // Unstable lock: high 5, low 1, high.
        do_reset();
        hold(1'b0, 10);
        hold(1'b1, 5);
        hold(1'b0, 1);
        hold(1'b1, 30);

        // Lock never arrives: periodic re-pulse.
        do_reset();
        hold(1'b0, 80);

        // Randomized lock waveforms with occasional mid-sequence resets.
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            bit v;
            int len;
            v   = ($urandom_range(0, 3) != 0);
            len = v ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
            hold(v, len);
            if ($urandom_range(0, 14) == 0) do_reset();
        end

        // Saturation: lock held low long enough for more than 255 attempts.
        do_reset();
        hold(1'b0, 256 * (RST_PULSE + LOCK_TIMEOUT) + 30);
        chk("retry_sat", 32'(retry_cnt), 32'd255);

        // Reach RELEASE with bit 0 released, then async reset mid-sequence.
        for (int i = 0; i < 200 && !(m_phase == 3 && m_t == 2); i++) step(1'b1);
        chk("in_release", 32'(state_o), 32'd3);
        chk("release_bit0", 32'(rst_n_o), 32'(3'b001));
        rst_n = 1'b0;
        #1;
        chk("async_pll_rst", 32'(pll_rst),   32'd1);
        chk("async_rst_n_o", 32'(rst_n_o),   32'd0);
        chk("async_ready",   32'(ready),     32'd0);
        chk("async_state",   32'(state_o),   32'd0);
        chk("async_retry",   32'(retry_cnt), 32'd0);

        // Sequence restarts cleanly after the mid-run reset.
        do_reset();
        hold(1'b0, 10);
        hold(1'b1, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
